// File: rtl/controller.sv
// Control FSM for a small accumulator CPU.
// Sequences fetch / decode / execute and drives the datapath strobes.
// The state register is one-hot and is exported directly as S0..S5.
// Strobes that depend only on state are registered. Each one is computed from the
// next state, so it is valid in the same cycle as the state it belongs to.
// Only CL (reset mirror) and LD_PC (branch decision in S1) are combinational.
module controller (
   input  logic CLK,
   input  logic RESET,
   input  logic CLR,
   input  logic ADD,
   input  logic SUB,
   input  logic STORE,
   input  logic BNZ,
   input  logic ZERO,
   output logic ADDSUB,
   output logic CL,
   output logic CL_AC,
   output logic DORPC,
   output logic LD_AC,
   output logic LD_D,
   output logic LD_IR,
   output logic LD_PC,
   output logic MEM_EN,
   output logic PC_CNT,
   output logic RORW,
   output logic S0,
   output logic S1,
   output logic S2,
   output logic S3,
   output logic S4,
   output logic S5
);

   typedef enum logic [5:0] {
      ST_FETCH  = 6'b000001,
      ST_DECODE = 6'b000010,
      ST_CLEAR  = 6'b000100,
      ST_READ   = 6'b001000,
      ST_EXEC   = 6'b010000,
      ST_STORE  = 6'b100000
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   r_sub_flag;
   logic   w_next_sub;

   logic   r_addsub;
   logic   r_cl_ac;
   logic   r_dorpc;
   logic   r_ld_ac;
   logic   r_ld_d;
   logic   r_ld_ir;
   logic   r_mem_en;
   logic   r_pc_cnt;
   logic   r_rorw;

   logic   w_addsub;
   logic   w_cl_ac;
   logic   w_dorpc;
   logic   w_ld_ac;
   logic   w_ld_d;
   logic   w_ld_ir;
   logic   w_mem_en;
   logic   w_pc_cnt;
   logic   w_rorw;
   logic   w_bnz_taken;

   // Next-state selection; opcodes only matter in DECODE, illegal codes fall back to FETCH
   always_comb begin
      w_next     = ST_FETCH;
      w_next_sub = r_sub_flag;
      case (r_state)
         ST_FETCH:  w_next = ST_DECODE;
         ST_DECODE: begin
            if (CLR) begin
               w_next = ST_CLEAR;
            end else if (ADD) begin
               w_next     = ST_READ;
               w_next_sub = 1'b0;
            end else if (SUB) begin
               w_next     = ST_READ;
               w_next_sub = 1'b1;
            end else if (STORE) begin
               w_next = ST_STORE;
            end else begin
               w_next = ST_FETCH;
            end
         end
         ST_CLEAR:  w_next = ST_FETCH;
         ST_READ:   w_next = ST_EXEC;
         ST_EXEC:   w_next = ST_FETCH;
         ST_STORE:  w_next = ST_FETCH;
         default:   w_next = ST_FETCH;
      endcase
   end

   // Moore strobes for the state being entered, latched together with the state
   always_comb begin
      w_addsub = 1'b0;
      w_cl_ac  = 1'b0;
      w_dorpc  = 1'b0;
      w_ld_ac  = 1'b0;
      w_ld_d   = 1'b0;
      w_ld_ir  = 1'b0;
      w_mem_en = 1'b0;
      w_pc_cnt = 1'b0;
      w_rorw   = 1'b0;
      case (w_next)
         ST_FETCH: begin
            w_mem_en = 1'b1;
            w_rorw   = 1'b1;
            w_ld_ir  = 1'b1;
            w_pc_cnt = 1'b1;
         end
         ST_CLEAR: begin
            w_cl_ac = 1'b1;
         end
         ST_READ: begin
            w_mem_en = 1'b1;
            w_rorw   = 1'b1;
            w_dorpc  = 1'b1;
            w_ld_d   = 1'b1;
            w_addsub = w_next_sub;
         end
         ST_EXEC: begin
            w_ld_ac  = 1'b1;
            w_addsub = w_next_sub;
         end
         ST_STORE: begin
            w_mem_en = 1'b1;
            w_dorpc  = 1'b1;
         end
         default: begin
            w_addsub = 1'b0;
         end
      endcase
   end

   // Branch is taken in DECODE only when no higher-priority opcode is present and AC is non-zero
   always_comb begin
      w_bnz_taken = (r_state == ST_DECODE) & BNZ & ~CLR & ~ADD & ~SUB & ~STORE & ~ZERO;
   end

   // State, operation flag and registered strobes; reset parks the FSM in FETCH
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state    <= ST_FETCH;
         r_sub_flag <= 1'b0;
         r_addsub   <= 1'b0;
         r_cl_ac    <= 1'b0;
         r_dorpc    <= 1'b0;
         r_ld_ac    <= 1'b0;
         r_ld_d     <= 1'b0;
         r_ld_ir    <= 1'b1;
         r_mem_en   <= 1'b1;
         r_pc_cnt   <= 1'b1;
         r_rorw     <= 1'b1;
      end else begin
         r_state    <= w_next;
         r_sub_flag <= w_next_sub;
         r_addsub   <= w_addsub;
         r_cl_ac    <= w_cl_ac;
         r_dorpc    <= w_dorpc;
         r_ld_ac    <= w_ld_ac;
         r_ld_d     <= w_ld_d;
         r_ld_ir    <= w_ld_ir;
         r_mem_en   <= w_mem_en;
         r_pc_cnt   <= w_pc_cnt;
         r_rorw     <= w_rorw;
      end
   end

   assign CL     = ~RESET;
   assign LD_PC  = w_bnz_taken;
   assign ADDSUB = r_addsub;
   assign CL_AC  = r_cl_ac;
   assign DORPC  = r_dorpc;
   assign LD_AC  = r_ld_ac;
   assign LD_D   = r_ld_d;
   assign LD_IR  = r_ld_ir;
   assign MEM_EN = r_mem_en;
   assign PC_CNT = r_pc_cnt;
   assign RORW   = r_rorw;
   assign {S5, S4, S3, S2, S1, S0} = r_state;

endmodule

// File: tb/tb_controller.sv
// Testbench for the accumulator-CPU control FSM.
// A driver issues whole instructions. For each cycle it pushes the expected
// state/strobe vector onto a queue, and a monitor compares one vector per
// falling clock edge.
module tb_controller;

   logic CLK = 1'b0;
   logic RESET, CLR, ADD, SUB, STORE, BNZ, ZERO;
   logic ADDSUB, CL, CL_AC, DORPC, LD_AC, LD_D, LD_IR, LD_PC;
   logic MEM_EN, PC_CNT, RORW, S0, S1, S2, S3, S4, S5;

   controller dut (
      .CLK(CLK), .RESET(RESET), .CLR(CLR), .ADD(ADD), .SUB(SUB), .STORE(STORE),
      .BNZ(BNZ), .ZERO(ZERO), .ADDSUB(ADDSUB), .CL(CL), .CL_AC(CL_AC),
      .DORPC(DORPC), .LD_AC(LD_AC), .LD_D(LD_D), .LD_IR(LD_IR), .LD_PC(LD_PC),
      .MEM_EN(MEM_EN), .PC_CNT(PC_CNT), .RORW(RORW),
      .S0(S0), .S1(S1), .S2(S2), .S3(S3), .S4(S4), .S5(S5)
   );

   always #5 CLK = ~CLK;

   logic [16:0] exp_q[$];
   string       name_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          running = 1'b0;
   int          instr_n = 0;

   // Vector order: S5..S0, CL, CL_AC, LD_AC, LD_D, LD_IR, LD_PC, MEM_EN, PC_CNT, RORW, DORPC, ADDSUB
   function automatic logic [16:0] dut_vec();
      return {S5, S4, S3, S2, S1, S0, CL, CL_AC, LD_AC, LD_D, LD_IR, LD_PC,
              MEM_EN, PC_CNT, RORW, DORPC, ADDSUB};
   endfunction

   // Expected outputs for a state number 0..5 taken straight from the state table
   function automatic logic [16:0] expv(input int st, input bit cl, input bit sb, input bit lp);
      logic [5:0] oh;
      oh = 6'(1) << st;
      return {oh, cl,
              1'(st == 2),                        // CL_AC
              1'(st == 4),                        // LD_AC
              1'(st == 3),                        // LD_D
              1'(st == 0),                        // LD_IR
              1'((st == 1) && lp),                // LD_PC
              1'(st == 0 || st == 3 || st == 5),  // MEM_EN
              1'(st == 0),                        // PC_CNT
              1'(st == 0 || st == 3),             // RORW
              1'(st == 3 || st == 5),             // DORPC
              1'((st == 3 || st == 4) && sb)};    // ADDSUB
   endfunction

   task automatic cyc(input logic [16:0] e, input string nm);
      exp_q.push_back(e);
      name_q.push_back(nm);
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [4:0] opc, input logic z);
      {CLR, ADD, SUB, STORE, BNZ} = opc;
      ZERO = z;
   endtask

   // One instruction: opc = {CLR,ADD,SUB,STORE,BNZ}; abort_at >= 0 pulls reset in that cycle
   task automatic do_instr(input logic [4:0] opc, input logic z, input int abort_at);
      int seq[$];
      bit sb;
      bit lp;
      sb = 1'b0;
      lp = 1'b0;
      if (opc[4])      seq = '{0, 1, 2};
      else if (opc[3]) seq = '{0, 1, 3, 4};
      else if (opc[2]) begin seq = '{0, 1, 3, 4}; sb = 1'b1; end
      else if (opc[1]) seq = '{0, 1, 5};
      else begin seq = '{0, 1}; lp = opc[0] & ~z; end
      for (int k = 0; k < seq.size(); k++) begin
         RESET = 1'b1;
         if (k == 1) drive(opc, z);
         else        drive(5'($urandom), 1'($urandom));
         if (k == abort_at) begin
            RESET = 1'b0;
            cyc(expv(0, 1'b1, 1'b0, 1'b0), $sformatf("abort_i%0d_k%0d", instr_n, k));
            cyc(expv(0, 1'b1, 1'b0, 1'b0), $sformatf("abort_hold_i%0d", instr_n));
            instr_n++;
            return;
         end
         cyc(expv(seq[k], 1'b0, sb, lp), $sformatf("i%0d_op%b_z%0d_k%0d", instr_n, opc, z, k));
      end
      instr_n++;
   endtask

   // Monitor: one comparison per cycle, on the falling edge
   initial begin
      logic [16:0] e;
      logic [16:0] g;
      string       nm;
      @(posedge CLK);
      forever begin
         @(negedge CLK);
         if (!running) break;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL underflow: DUT vector %b with no expectation queued", dut_vec());
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g  = dut_vec();
            if (g !== e) begin
               errors++;
               $display("FAIL %s got %b expected %b", nm, g, e);
            end
         end
      end
   end

   // Driver: reset, directed instructions, then randomized instruction stream
   initial begin
      logic [4:0] opc;
      int         r;
      running = 1'b1;
      RESET = 1'b0;
      drive(5'b0, 1'b0);
      @(posedge CLK);
      #1;
      cyc(expv(0, 1'b1, 1'b0, 1'b0), "reset0");
      cyc(expv(0, 1'b1, 1'b0, 1'b0), "reset1");

      do_instr(5'b10000, 1'b0, -1);   // CLR
      do_instr(5'b10000, 1'b1, -1);   // CLR again
      do_instr(5'b01000, 1'b0, -1);   // ADD
      do_instr(5'b00100, 1'b0, -1);   // SUB
      do_instr(5'b00010, 1'b0, -1);   // STORE
      do_instr(5'b00001, 1'b0, -1);   // BNZ taken
      do_instr(5'b00001, 1'b1, -1);   // BNZ not taken
      do_instr(5'b00000, 1'b0, -1);   // NOP
      do_instr(5'b11000, 1'b0, -1);   // CLR beats ADD
      do_instr(5'b01100, 1'b0, -1);   // ADD beats SUB
      do_instr(5'b00011, 1'b0, -1);   // STORE beats BNZ
      do_instr(5'b00100, 1'b0, 3);    // reset in EXECUTE of SUB
      do_instr(5'b01000, 1'b0, 2);    // reset in OPERAND READ
      do_instr(5'b00100, 1'b0, -1);   // SUB after abort

      for (int i = 0; i < 400; i++) begin
         r   = $urandom_range(0, 5);
         opc = (r < 5) ? 5'(5'b1 << r) : 5'b0;
         if (r < 5 && $urandom_range(0, 2) == 0)
            opc = opc | (5'($urandom) & 5'((5'b1 << r) - 5'd1));
         do_instr(opc, 1'($urandom),
                  ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : -1);
      end

      running = 1'b0;
      #20;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: %0d expectations unchecked, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/controller.md
Name: controller

Overview:
- Moore-style control FSM for a simple accumulator CPU (PC, IR, D register, accumulator AC, ALU, single memory port).
- Sequences fetch, decode and execute from one-hot decoded opcode inputs plus the AC zero flag.
- Drives all datapath load, clear and select strobes.
- Exposes its one-hot state S0..S5 for debug.

Parameters:
- none

Ports:
- CLK  in  1  system clock; all state changes on rising edge
- RESET  in  1  asynchronous, active-low reset
- CLR  in  1  decoded opcode: clear accumulator
- ADD  in  1  decoded opcode: AC <= AC + mem[addr]
- SUB  in  1  decoded opcode: AC <= AC - mem[addr]
- STORE  in  1  decoded opcode: mem[addr] <= AC
- BNZ  in  1  decoded opcode: branch to addr if AC != 0
- ZERO  in  1  AC == 0 flag from datapath
- ADDSUB  out  1  ALU op select: 0 = add, 1 = subtract
- CL  out  1  datapath global clear; high while RESET is low
- CL_AC  out  1  synchronous accumulator clear
- DORPC  out  1  memory address mux select: 0 = PC, 1 = IR address field
- LD_AC  out  1  load AC from ALU
- LD_D  out  1  load D register from memory data
- LD_IR  out  1  load IR from memory data
- LD_PC  out  1  load PC from IR address field (branch)
- MEM_EN  out  1  memory enable
- PC_CNT  out  1  increment PC
- RORW  out  1  memory direction: 1 = read, 0 = write
- S0..S5  out  1 each  one-hot state indicators

Behaviour:
- State register is one-hot, 6 bits. Exactly one of S0..S5 is high at all times outside reset transients.
- RESET low (async): state <= S0, internal sub_flag <= 0, CL = 1. CL is combinational, equal to ~RESET.
- Outputs not listed for a state are 0. DORPC and ADDSUB are 0 unless stated.
- S0 FETCH
  - Outputs: MEM_EN=1, RORW=1, DORPC=0, LD_IR=1, PC_CNT=1.
  - Next: S1 unconditionally.
- S1 DECODE
  - Opcode priority: CLR > ADD > SUB > STORE > BNZ.
  - CLR -> S2.
  - ADD -> S3, capture sub_flag <= 0.
  - SUB -> S3, capture sub_flag <= 1.
  - STORE -> S5.
  - BNZ with ZERO=0: LD_PC=1 in this state (combinational on inputs), next S0.
  - BNZ with ZERO=1: no load, next S0.
  - No opcode asserted: NOP, next S0.
- S2 CLEAR: CL_AC=1; next S0.
- S3 OPERAND READ
  - Outputs: MEM_EN=1, RORW=1, DORPC=1, LD_D=1, ADDSUB=sub_flag.
  - Next: S4.
- S4 EXECUTE: LD_AC=1, ADDSUB=sub_flag; next S0.
- S5 STORE: MEM_EN=1, RORW=0, DORPC=1; next S0.
- Instruction latency (cycles from S0 entry to next S0):
  - CLR 3
  - ADD/SUB 4
  - STORE 3
  - BNZ / NOP 2
- Opcode inputs are sampled only in S1. Changes in other states have no effect.
- sub_flag holds through S3 and S4 even if SUB/ADD drop.
- Reset mid-instruction aborts immediately to S0 with no further strobes.
- First rising edge after RESET deasserts executes S0 -> S1.
- Unreachable or illegal one-hot codes recover to S0 on the next clock.

Test Plan:
- Reset: RESET=0 -> S0=1, S1..S5=0, CL=1, MEM_EN=1, LD_IR=1, PC_CNT=1. Release -> CL=0; next edge S1=1.
- CLR=1 held -> state sequence S0,S1,S2,S0 repeating; CL_AC=1 only in S2; no LD_AC, LD_D or LD_PC pulses.
- ADD=1 -> S0,S1,S3,S4 loop; in S3 LD_D=1, DORPC=1, RORW=1; in S4 LD_AC=1; ADDSUB=0 throughout. SUB=1 -> same sequence with ADDSUB=1 in S3 and S4.
- STORE=1 -> S0,S1,S5; in S5 MEM_EN=1, RORW=0, DORPC=1; then back to S0.
- BNZ=1, ZERO=0 -> LD_PC=1 during S1, then S0. With ZERO=1 -> LD_PC stays 0, S1 -> S0. ZERO toggling outside S1 has no effect.
- Priority/mid-op: CLR=ADD=1 -> S2 taken. SUB dropped while in S3 -> ADDSUB stays 1 through S4. RESET pulsed low in S4 -> S0 immediately, LD_AC=0.
